// File: rtl/conv_stream_sequencer.sv
// Control sequencer for the 2-D convolution engine: loads kernels, streams image rows into the
// line buffer, runs a K*K-tap MAC per window and filter, and writes each result through a req/ack port.
module conv_stream_sequencer #(
  parameter int NUM_FILTERS = 4,
  parameter int K           = 3,
  parameter int IMG_W       = 16,
  parameter int IMG_H       = 16,
  parameter int STRIDE      = 1,
  parameter int AW          = 16,
  parameter int FILT_BASE   = 0,
  parameter int IMG_BASE    = 256,
  parameter int OUT_BASE    = 1024,
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int TW = (K > 1) ? $clog2(K * K) : 1,
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   mem_rd_ack_i,
  input  logic                   mem_wr_ack_i,
  output logic                   mem_rd_req_o,
  output logic [AW-1:0]          mem_rd_addr_o,
  output logic                   mem_wr_req_o,
  output logic [AW-1:0]          mem_wr_addr_o,
  output logic [NUM_FILTERS-1:0] filter_wr_en_o,
  output logic [TW-1:0]          tap_idx_o,
  output logic                   line_wr_en_o,
  output logic [CW-1:0]          line_col_o,
  output logic                   line_shift_o,
  output logic                   win_load_o,
  output logic [CW-1:0]          win_col_o,
  output logic                   mac_clr_o,
  output logic                   mac_en_o,
  output logic [FW-1:0]          filter_sel_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int RW    = $clog2(IMG_H + 1);
  localparam int OYW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [FW-1:0]  F_LAST     = FW'(NUM_FILTERS - 1);
  localparam logic [TW-1:0]  TAP_LAST   = TW'(K * K - 1);
  localparam logic [CW-1:0]  COL_LAST   = CW'(IMG_W - 1);
  localparam logic [CW-1:0]  OX_LAST    = CW'(OUT_W - 1);
  localparam logic [OYW-1:0] OY_LAST    = OYW'(OUT_H - 1);
  localparam logic [RW-1:0]  ROWS_FIRST = RW'(K);
  localparam logic [RW-1:0]  ROWS_STEP  = RW'(STRIDE);

  if (K > IMG_W || K > IMG_H || STRIDE < 1) begin : g_bad_geometry
    $error("conv_stream_sequencer: kernel larger than image or STRIDE < 1");
  end else if (((IMG_W - K) % STRIDE) != 0 || ((IMG_H - K) % STRIDE) != 0) begin : g_bad_stride
    $error("conv_stream_sequencer: STRIDE does not tile the image exactly");
  end

  typedef enum logic [3:0] {
    IDLE, LD_FILT, LD_LINE, SHIFT, WIN, MAC, WRITE, NEXT, DONE
  } state_e;

  state_e         state_q, state_d;
  logic [FW-1:0]  f_q, f_d;
  logic [TW-1:0]  i_q, i_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic [CW-1:0]  ox_q, ox_d;
  logic [OYW-1:0] oy_q, oy_d;
  logic [RW-1:0]  phRows_q, phRows_d;
  logic           first_q, first_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      f_q      <= '0;
      i_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      phRows_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      f_q      <= f_d;
      i_q      <= i_d;
      row_q    <= row_d;
      col_q    <= col_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      phRows_q <= phRows_d;
      first_q  <= first_d;
    end
  end

  assign busy_o = (state_q != IDLE);

  always_comb begin
    state_d        = state_q;
    f_d            = f_q;
    i_d            = i_q;
    row_d          = row_q;
    col_d          = col_q;
    ox_d           = ox_q;
    oy_d           = oy_q;
    phRows_d       = phRows_q;
    first_d        = first_q;
    mem_rd_req_o   = 1'b0;
    mem_rd_addr_o  = '0;
    mem_wr_req_o   = 1'b0;
    mem_wr_addr_o  = '0;
    filter_wr_en_o = '0;
    tap_idx_o      = '0;
    line_wr_en_o   = 1'b0;
    line_col_o     = '0;
    line_shift_o   = 1'b0;
    win_load_o     = 1'b0;
    win_col_o      = '0;
    mac_clr_o      = 1'b0;
    mac_en_o       = 1'b0;
    filter_sel_o   = '0;
    done_o         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          f_d      = '0;
          i_d      = '0;
          row_d    = '0;
          col_d    = '0;
          ox_d     = '0;
          oy_d     = '0;
          phRows_d = '0;
          first_d  = 1'b1;
          state_d  = LD_FILT;
        end
      end
      LD_FILT: begin
        mem_rd_req_o  = 1'b1;
        mem_rd_addr_o = AW'(FILT_BASE) + AW'(f_q) * AW'(K * K) + AW'(i_q);
        tap_idx_o     = i_q;
        if (mem_rd_ack_i) begin
          filter_wr_en_o = NUM_FILTERS'(1) << f_q;
          if (i_q == TAP_LAST) begin
            i_d = '0;
            if (f_q == F_LAST) begin
              f_d     = '0;
              state_d = LD_LINE;
            end else begin
              f_d = f_q + FW'(1);
            end
          end else begin
            i_d = i_q + TW'(1);
          end
        end
      end
      LD_LINE: begin
        mem_rd_req_o  = 1'b1;
        mem_rd_addr_o = AW'(IMG_BASE) + AW'(row_q) * AW'(IMG_W) + AW'(col_q);
        line_col_o    = col_q;
        if (mem_rd_ack_i) begin
          line_wr_en_o = 1'b1;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = SHIFT;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      SHIFT: begin
        // The first phase primes K rows; each later output row needs only STRIDE new rows.
        line_shift_o = 1'b1;
        row_d        = row_q + RW'(1);
        if (phRows_q + RW'(1) == (first_q ? ROWS_FIRST : ROWS_STEP)) begin
          phRows_d = '0;
          first_d  = 1'b0;
          state_d  = WIN;
        end else begin
          phRows_d = phRows_q + RW'(1);
          state_d  = LD_LINE;
        end
      end
      WIN: begin
        win_load_o   = 1'b1;
        mac_clr_o    = 1'b1;
        win_col_o    = ox_q * CW'(STRIDE);
        filter_sel_o = f_q;
        i_d          = '0;
        state_d      = MAC;
      end
      MAC: begin
        mac_en_o     = 1'b1;
        tap_idx_o    = i_q;
        filter_sel_o = f_q;
        if (i_q == TAP_LAST) begin
          i_d     = '0;
          state_d = WRITE;
        end else begin
          i_d = i_q + TW'(1);
        end
      end
      WRITE: begin
        mem_wr_req_o  = 1'b1;
        mem_wr_addr_o = AW'(OUT_BASE) + AW'(f_q) * AW'(OUT_W * OUT_H)
                        + AW'(oy_q) * AW'(OUT_W) + AW'(ox_q);
        filter_sel_o  = f_q;
        if (mem_wr_ack_i) state_d = NEXT;
      end
      NEXT: begin
        // Filters iterate fastest so one loaded window serves every kernel.
        state_d = WIN;
        if (f_q != F_LAST) begin
          f_d = f_q + FW'(1);
        end else begin
          f_d = '0;
          if (ox_q != OX_LAST) begin
            ox_d = ox_q + CW'(1);
          end else begin
            ox_d = '0;
            if (oy_q == OY_LAST) begin
              state_d = DONE;
            end else begin
              oy_d    = oy_q + OYW'(1);
              state_d = LD_LINE;
            end
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
